cart_mbc1: RTL

Cartridge-side responder for the boy core's cartridge bus (a, dout, din, wr, rd). It implements an MBC1-style bank controller: it decodes CPU writes into bank and control registers and translates CPU addresses into physical ROM and RAM addresses for on-board synchronous memories (BRAM/SPRAM). It sits in the board top level between boy and the memory macros and drives boy's din.

---
 rtl/cart_pkg.sv | 40 ++++
 rtl/mbc1_bank_regs.sv | 56 +++++
 rtl/cart_mbc1.sv | 111 +++++++++++
 3 files changed

// File: rtl/cart_pkg.sv
// cart_pkg: shared constants and types for the MBC1 cartridge responder.
//   - CPU address regions (base/limit pairs, each a power-of-two aligned block)
//   - RAM enable magic nibble and the open-bus read value
//   - read-path source select type
//   - in_region(): aligned block match used by the decoders
package cart_pkg;

    localparam logic [15:0] ROM0_BASE   = 16'h0000;
    localparam logic [15:0] ROM0_LIMIT  = 16'h3FFF;
    localparam logic [15:0] ROMX_BASE   = 16'h4000;
    localparam logic [15:0] ROMX_LIMIT  = 16'h7FFF;
    localparam logic [15:0] RAMEN_BASE  = 16'h0000;
    localparam logic [15:0] RAMEN_LIMIT = 16'h1FFF;
    localparam logic [15:0] BANK1_BASE  = 16'h2000;
    localparam logic [15:0] BANK1_LIMIT = 16'h3FFF;
    localparam logic [15:0] BANK2_BASE  = 16'h4000;
    localparam logic [15:0] BANK2_LIMIT = 16'h5FFF;
    localparam logic [15:0] MODE_BASE   = 16'h6000;
    localparam logic [15:0] MODE_LIMIT  = 16'h7FFF;
    localparam logic [15:0] XRAM_BASE   = 16'hA000;
    localparam logic [15:0] XRAM_LIMIT  = 16'hBFFF;

    localparam logic [3:0] RAM_EN_MAGIC = 4'hA;
    localparam logic [7:0] OPEN_BUS     = 8'hFF;

    typedef enum logic [1:0] {
        SEL_ROM  = 2'd0,
        SEL_RAM  = 2'd1,
        SEL_OPEN = 2'd2
    } sel_t;

    // All regions are aligned power-of-two blocks, so a masked compare of the
    // fixed address bits is enough (and avoids unsigned >= 0 comparisons).
    function automatic logic in_region(input logic [15:0] addr,
                                       input logic [15:0] base,
                                       input logic [15:0] limit);
        return (addr & ~(base ^ limit)) == base;
    endfunction

endpackage

// File: rtl/mbc1_bank_regs.sv
// mbc1_bank_regs: CPU write edge detector and the MBC1 control registers.
// Ports:
//   clk, rst      core clock, asynchronous active-high reset
//   a             CPU address
//   wdata         CPU write data, low 5 bits (the only bits any register uses)
//   wr            CPU write strobe (level, held several cycles)
//   wr_rise       one-cycle pulse on the first cycle of each CPU write
//   bank1         ROM bank low bits (never 0)
//   bank2         ROM high bits / RAM bank
//   mode          banking mode (0: simple, 1: advanced)
//   ram_en        external RAM enabled
module mbc1_bank_regs
    import cart_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a,
    input  logic [4:0]  wdata,
    input  logic        wr,
    output logic        wr_rise,
    output logic [4:0]  bank1,
    output logic [1:0]  bank2,
    output logic        mode,
    output logic        ram_en
);

    logic wr_q;

    // wr_q resets high so a strobe still held when reset releases is not
    // mistaken for a new write; the detector re-arms once wr drops.
    assign wr_rise = wr & ~wr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q   <= 1'b1;
            bank1  <= 5'd1;
            bank2  <= 2'd0;
            mode   <= 1'b0;
            ram_en <= 1'b0;
        end else begin
            wr_q <= wr;
            if (wr_rise) begin
                if (in_region(a, RAMEN_BASE, RAMEN_LIMIT))
                    ram_en <= (wdata[3:0] == RAM_EN_MAGIC);
                // Bank 0 is not selectable in the switchable window.
                if (in_region(a, BANK1_BASE, BANK1_LIMIT))
                    bank1 <= (wdata == 5'd0) ? 5'd1 : wdata;
                if (in_region(a, BANK2_BASE, BANK2_LIMIT))
                    bank2 <= wdata[1:0];
                if (in_region(a, MODE_BASE, MODE_LIMIT))
                    mode <= wdata[0];
            end
        end
    end

endmodule

// File: rtl/cart_mbc1.sv
// cart_mbc1: MBC1-style cartridge responder between the boy core and the
// on-board ROM/RAM macros.
// Ports:
//   clk, rst     core clock, asynchronous active-high reset
//   a            CPU address
//   cpu_wdata    CPU write data
//   wr, rd       CPU write / read strobes (levels)
//   cpu_rdata    read data back to the CPU (valid 1 clk after a is stable)
//   rom_addr     physical ROM address (combinational)
//   rom_rdata    ROM data, 1 clk after rom_addr
//   ram_addr     physical RAM address (combinational)
//   ram_we       one-cycle RAM write pulse
//   ram_wdata    RAM write data
//   ram_rdata    RAM data, 1 clk after ram_addr
module cart_mbc1
    import cart_pkg::*;
#(
    parameter int ROM_ADDR_W = 21,
    parameter int RAM_ADDR_W = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           a,
    input  logic [7:0]            cpu_wdata,
    input  logic                  wr,
    input  logic                  rd,
    output logic [7:0]            cpu_rdata,
    output logic [ROM_ADDR_W-1:0] rom_addr,
    input  logic [7:0]            rom_rdata,
    output logic [RAM_ADDR_W-1:0] ram_addr,
    output logic                  ram_we,
    output logic [7:0]            ram_wdata,
    input  logic [7:0]            ram_rdata
);

    logic       wr_rise;
    logic [4:0] bank1;
    logic [1:0] bank2;
    logic       mode;
    logic       ram_en;

    logic       is_rom;
    logic       is_xram;
    logic [6:0] rom_bank;
    logic [1:0] ram_bank;
    logic [20:0] rom_full;
    logic [14:0] ram_full;
    sel_t       sel_q;

    // Reads are fully address-driven; the strobe is not needed to steer data.
    logic rd_unused;
    assign rd_unused = rd;

    mbc1_bank_regs u_regs (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .wdata   (cpu_wdata[4:0]),
        .wr      (wr),
        .wr_rise (wr_rise),
        .bank1   (bank1),
        .bank2   (bank2),
        .mode    (mode),
        .ram_en  (ram_en)
    );

    assign is_rom  = in_region(a, ROM0_BASE, ROM0_LIMIT) | in_region(a, ROMX_BASE, ROMX_LIMIT);
    assign is_xram = in_region(a, XRAM_BASE, XRAM_LIMIT);

    // Upper window always uses both bank registers; the lower window is
    // bank 0 unless advanced mode lets bank2 select a 512 KiB quadrant.
    always_comb begin
        if (a[14])
            rom_bank = {bank2, bank1};
        else if (mode)
            rom_bank = {bank2, 5'b0};
        else
            rom_bank = 7'd0;
    end

    assign ram_bank = mode ? bank2 : 2'd0;
    assign rom_full = {rom_bank, a[13:0]};
    assign ram_full = {ram_bank, a[12:0]};
    assign rom_addr = ROM_ADDR_W'(rom_full);
    assign ram_addr = RAM_ADDR_W'(ram_full);

    assign ram_we    = wr_rise & is_xram & ram_en;
    assign ram_wdata = cpu_wdata;

    // Source select lines up with the one-cycle memory read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sel_q <= SEL_OPEN;
        else if (is_rom)
            sel_q <= SEL_ROM;
        else if (is_xram && ram_en)
            sel_q <= SEL_RAM;
        else
            sel_q <= SEL_OPEN;
    end

    always_comb begin
        cpu_rdata = OPEN_BUS;
        case (sel_q)
            SEL_ROM:  cpu_rdata = rom_rdata;
            SEL_RAM:  cpu_rdata = ram_rdata;
            default:  cpu_rdata = OPEN_BUS;
        endcase
    end

endmodule
